// File: rtl/viterbi_channel_err_inj.sv
// viterbi_channel_err_inj: channel model XORing encoder symbols with clean/periodic/random/burst error masks; `CHAN_ERR_LOG_EN adds last_err_word_o
module viterbi_channel_err_inj #(
  parameter int CNT_W = 16,
  parameter int PERIOD = 8,
  parameter int MIN_GAP = 4,
  parameter int BURST_LEN = 3,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable_i,
  input  logic [1:0]       enc_i,
  input  logic [1:0]       mode_i,
  input  logic [8:0]       thresh_i,
  output logic [1:0]       chan_o,
  output logic             chan_valid_o,
  output logic [1:0]       err_inj_o,
  output logic [CNT_W-1:0] word_ct_o,
  output logic [CNT_W-1:0] error_counter_o
`ifdef CHAN_ERR_LOG_EN
  ,
  output logic [CNT_W-1:0] last_err_word_o
`endif
);
  localparam int PW = $clog2(PERIOD);
  localparam logic [15:0] MG = (MIN_GAP < 1) ? 16'd1 : 16'(MIN_GAP);
  localparam logic [15:0] BL1 = 16'(BURST_LEN - 1);
  typedef enum logic [1:0] {GAP, ARMED, BURST} state_t;
  state_t state, state_n;
  logic [15:0] lfsr, gap_cnt, gap_n, burst_cnt, burst_n;
  logic [PW-1:0] period_cnt;
  logic toggle, toggle_n, trig, pend;
  logic [1:0] mask;
  logic [CNT_W:0] ec_sum;
  assign trig = {1'b0, lfsr[7:0]} < thresh_i;
  assign pend = period_cnt == PW'(PERIOD - 1);
  assign ec_sum = {1'b0, error_counter_o} + (CNT_W+1)'(mask[0]) + (CNT_W+1)'(mask[1]);
  always_comb begin
    state_n = state;
    gap_n = gap_cnt;
    burst_n = burst_cnt;
    toggle_n = toggle;
    mask = 2'b00;
    if (mode_i == 2'b00) begin
      state_n = GAP;
      gap_n = MG;
    end else begin
      case (state)
        GAP:
          if (gap_cnt <= 16'd1) state_n = ARMED;
          else gap_n = gap_cnt - 16'd1;
        ARMED:
          if (mode_i == 2'b01 && pend) begin
            mask = toggle ? 2'b10 : 2'b01;
            toggle_n = !toggle;
            state_n = GAP;
            gap_n = MG;
          end else if (mode_i == 2'b10 && trig) begin
            mask = lfsr[8] ? 2'b10 : 2'b01;
            state_n = GAP;
            gap_n = MG;
          end else if (mode_i == 2'b11 && trig) begin
            mask = 2'b01;
            burst_n = BL1;
            state_n = (BURST_LEN == 1) ? GAP : BURST;
            gap_n = MG;
          end
        BURST:
          if (mode_i != 2'b11) begin
            state_n = GAP;
            gap_n = MG;
          end else begin
            mask = 2'b01;
            if (burst_cnt <= 16'd1) begin
              state_n = GAP;
              gap_n = MG;
            end else burst_n = burst_cnt - 16'd1;
          end
        default: begin
          state_n = GAP;
          gap_n = MG;
        end
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= GAP;
      gap_cnt <= MG;
      burst_cnt <= '0;
      toggle <= 1'b0;
      lfsr <= LFSR_SEED;
      period_cnt <= '0;
      chan_o <= '0;
      chan_valid_o <= 1'b0;
      err_inj_o <= '0;
      word_ct_o <= '0;
      error_counter_o <= '0;
`ifdef CHAN_ERR_LOG_EN
      last_err_word_o <= '0;
`endif
    end else if (enable_i) begin
      state <= state_n;
      gap_cnt <= gap_n;
      burst_cnt <= burst_n;
      toggle <= toggle_n;
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      period_cnt <= pend ? '0 : period_cnt + 1'b1;
      chan_o <= enc_i ^ mask;
      chan_valid_o <= 1'b1;
      err_inj_o <= mask;
      word_ct_o <= word_ct_o + 1'b1;
      error_counter_o <= ec_sum[CNT_W] ? '1 : ec_sum[CNT_W-1:0];
`ifdef CHAN_ERR_LOG_EN
      if (|mask) last_err_word_o <= word_ct_o;
`endif
    end else chan_valid_o <= 1'b0;
  end
endmodule

// File: doc/viterbi_channel_err_inj.md
Name: viterbi_channel_err_inj

Overview:
Channel model between the convolutional encoder and the Viterbi decoder in the tx/rx chain. Takes one 2-bit encoded symbol pair per accepted word and XORs it with an error mask. The mask is chosen by a run-time mode: clean, periodic, LFSR-random or burst. A minimum clean-word gap between injections keeps errors within the decoder's correction capability. Also exports the word and error counters that the system bench reads as word_ct / err_inj / error_counter.

Parameters:
CNT_W, 16, width of the word and error counters.
PERIOD, 8, words per period in periodic mode (must be >= 2).
MIN_GAP, 4, clean words forced after every injection or burst (0 treated as 1).
BURST_LEN, 3, consecutive corrupted words per burst (must be >= 1).
LFSR_SEED, 16'hACE1, LFSR reset value (must be nonzero).

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
enable_i  in  1  word strobe from encoder; a word is accepted on a posedge with enable_i=1
enc_i  in  2  encoder symbol pair {d1,d0}
mode_i  in  2  00 clean, 01 periodic, 10 random, 11 burst; sampled per accepted word
thresh_i  in  9  random/burst trigger threshold; trigger when lfsr[7:0] < thresh_i (0 never, 256 always)
chan_o  out  2  corrupted symbol pair to decoder
chan_valid_o  out  1  chan_o updated this cycle
err_inj_o  out  2  mask applied to current chan_o
word_ct_o  out  CNT_W  accepted words, wraps
error_counter_o  out  CNT_W  total flipped bits, saturates at all-ones

Behaviour:
- rst wins over everything.
  - Reset values: outputs 0, LFSR=LFSR_SEED, period_cnt=0, toggle=0, state GAP, gap_cnt=MIN_GAP.
  - Reset mid-burst or mid-gap aborts immediately.
- Latency: 1 clock, fully registered.
  - Accepted word at edge N gives, at edge N: chan_o=enc_i^mask, err_inj_o=mask, chan_valid_o=1.
  - Same edge: word_ct_o+1, error_counter_o+popcount(mask) (saturating).
- enable_i=0: chan_valid_o<=0. chan_o, err_inj_o, counters, LFSR, period_cnt and FSM all hold.
- LFSR: 16-bit Fibonacci, feedback b15^b13^b12^b10, shift left, advances once per accepted word. Decisions use the pre-advance value.
- period_cnt: counts accepted words modulo PERIOD in every mode.
- FSM, evaluated per accepted word; all decisions are from the current word:
  - mode 00:
    - mask=0.
    - State forced to GAP, gap_cnt reloaded to MIN_GAP.
  - GAP:
    - mask=0.
    - If gap_cnt<=1, go to ARMED; else decrement gap_cnt.
  - ARMED, mode 01:
    - If period_cnt==PERIOD-1, mask = toggle ? 10 : 01, flip toggle, go to GAP (gap_cnt=MIN_GAP).
    - Otherwise mask=0.
    - A period end that occurs outside ARMED is skipped.
  - ARMED, mode 10:
    - If triggered, mask = lfsr[8] ? 10 : 01, go to GAP.
  - ARMED, mode 11:
    - If triggered, mask=01 and burst_cnt=BURST_LEN-1.
    - BURST_LEN==1 goes straight to GAP; otherwise go to BURST.
  - BURST:
    - mask=01.
    - If burst_cnt<=1, go to GAP (gap_cnt=MIN_GAP); else decrement burst_cnt.
    - mode_i!=11 aborts: mask=0, go to GAP with reload.
- Mode changes in ARMED/GAP take effect on the same word; the FSM state is retained.
- At most one bit is flipped per word (mask never 11).

Optional Feature:
CHAN_ERR_LOG_EN:
- Defined: adds output last_err_word_o [CNT_W-1:0], updated to the pre-increment word_ct on every word with a nonzero mask; reset 0.
- Undefined: port and register absent; everything else unchanged.

Test Plan:
1. rst, mode 00, 20 words enc_i=10 -> chan_o=10 each word, err_inj_o=0, word_ct_o=20, error_counter_o=0.
2. mode 01, defaults, 32 words enc_i=00 -> errors at word indices 7,15,23,31, masks 01,10,01,10, error_counter_o=4.
3. mode 10, thresh_i=0 for 100 words -> no errors. Then reset, thresh_i=256, 100 words -> errors at indices 4,9,...,99 (20 errors), each mask per lfsr[8].
4. mode 11, thresh_i=256, 14 words -> mask 01 on words 4,5,6,11,12,13; error_counter_o=6.
5. Repeat scenario 2 with enable_i low on every other cycle -> identical per-word results; chan_valid_o=0 on idle cycles; no counter or LFSR motion on idle cycles.
6. rst asserted during word 5 of scenario 4 -> next cycle all outputs 0. After release the sequence matches a fresh start (reseeded LFSR, first burst at word 4).
